// File: rtl/uart_frame_pkg.sv
// Shared framing constants and FSM state encoding for the UART point-frame
// receiver and transmit framer.
package uart_frame_pkg;

  localparam logic [7:0] BYTE_S = 8'h53;
  localparam logic [7:0] BYTE_T = 8'h54;
  localparam logic [7:0] BYTE_E = 8'h45;
  localparam logic [7:0] BYTE_N = 8'h4E;
  localparam logic [7:0] BYTE_D = 8'h44;

  localparam int unsigned FRAME_LEN = 9;
  localparam int unsigned PAY_LEN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_S,
    ST_PAY,
    ST_TAIL_E,
    ST_TAIL_N,
    ST_TAIL_D
  } frame_state_t;

  // Gap counter width: enough to hold TIMEOUT_CYCLES-1, never below one bit.
  function automatic int unsigned gap_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, flags the cycle in
// which the gap limit is reached unless a clear arrives in that same cycle.
module uart_gap_timer
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = gap_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  // A clear (new byte) in the limit cycle wins, so no expiry is reported.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Parses 9-byte "ST<H16><V16>END" frames from a UART byte stream, publishing
// the point on a good frame and counting aborted frames.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_DV,
  input  logic [7:0]  RX_BYTE,
  output logic [15:0] POINT_H,
  output logic [15:0] POINT_V,
  output logic        FRAME_VALID,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_CNT
);

  frame_state_t state, state_n;
  logic [1:0]   pay_idx, pay_idx_n;
  logic [31:0]  shadow, shadow_n;
  logic         accept;
  logic         abort;
  logic         timeout;
  logic         gap_enable;
  logic         gap_clear;

  assign gap_enable = (state != ST_IDLE);
  assign gap_clear  = RX_DV || !gap_enable;

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (gap_clear),
    .enable (gap_enable),
    .expired(timeout)
  );

  always_comb begin
    state_n   = state;
    pay_idx_n = pay_idx;
    shadow_n  = shadow;
    accept    = 1'b0;
    abort     = 1'b0;

    if (RX_DV) begin
      unique case (state)
        ST_IDLE: begin
          if (RX_BYTE == BYTE_S) state_n = ST_GOT_S;
        end
        ST_GOT_S: begin
          if (RX_BYTE == BYTE_T) begin
            state_n   = ST_PAY;
            pay_idx_n = '0;
          end else if (RX_BYTE != BYTE_S) begin
            abort = 1'b1;
          end
        end
        ST_PAY: begin
          shadow_n  = {shadow[23:0], RX_BYTE};
          pay_idx_n = pay_idx + 2'd1;
          if (pay_idx == 2'(PAY_LEN - 1)) state_n = ST_TAIL_E;
        end
        ST_TAIL_E: begin
          if (RX_BYTE == BYTE_E) state_n = ST_TAIL_N;
          else                   abort   = 1'b1;
        end
        ST_TAIL_N: begin
          if (RX_BYTE == BYTE_N) state_n = ST_TAIL_D;
          else                   abort   = 1'b1;
        end
        ST_TAIL_D: begin
          if (RX_BYTE == BYTE_D) begin
            accept  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            abort = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (timeout) begin
      abort = 1'b1;
    end

    // An offending 'S' may itself start the next frame.
    if (abort) begin
      shadow_n  = '0;
      pay_idx_n = '0;
      state_n   = (RX_DV && (RX_BYTE == BYTE_S)) ? ST_GOT_S : ST_IDLE;
    end

    if (accept) begin
      shadow_n  = '0;
      pay_idx_n = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      pay_idx     <= '0;
      shadow      <= '0;
      POINT_H     <= '0;
      POINT_V     <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      ERR_CNT     <= '0;
    end else begin
      state       <= state_n;
      pay_idx     <= pay_idx_n;
      shadow      <= shadow_n;
      FRAME_VALID <= accept;
      FRAME_ERR   <= abort;
      if (accept) begin
        POINT_H <= shadow[31:16];
        POINT_V <= shadow[15:0];
      end
      if (abort && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

endmodule
